// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Shares the single register-file write port between the MEM/WB pipeline slot
//   and a multi-cycle FPU. The pipeline always wins the port. FPU results wait in
//   a small in-order FIFO and drain into idle slots. A pipeline FPU write to a
//   register kills every older queued result for that register (WAW). A killed
//   entry keeps its slot and dequeues as a no-write.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_mem_valid/rd/regwrite/data
//                             MEM/WB slot (regwrite 01 int, 10 fpu, 00/11 none)
//   i_fpu_valid/rd/data       FPU result offer
//   o_fpu_ready               FIFO not full (state only)
//   o_rd_wb, o_write_data_register_wb, o_regwrite_wb
//                             registered register-file write port
//   o_fpu_pending             bit r set while a live queued result targets f<r>
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_valid,
  input  logic [4:0]  i_mem_rd,
  input  logic [1:0]  i_mem_regwrite,
  input  logic [31:0] i_mem_data,
  input  logic        i_fpu_valid,
  input  logic [4:0]  i_fpu_rd,
  input  logic [31:0] i_fpu_data,
  output logic        o_fpu_ready,
  output logic [4:0]  o_rd_wb,
  output logic [31:0] o_write_data_register_wb,
  output logic [1:0]  o_regwrite_wb,
  output logic [31:0] o_fpu_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;

  logic [4:0]  r_rd_wb;
  logic [31:0] r_data_wb;
  logic [1:0]  r_regwrite_wb;

  logic             w_full;
  logic             w_empty;
  logic             w_mem_wr_int;
  logic             w_mem_wr_fpu;
  logic             w_mem_wr;
  logic             w_enq;
  logic             w_deq;
  logic [DEPTH-1:0] w_live_nxt;
  logic [31:0]      w_pending;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Integer writes to x0 are dropped here so the slot counts as idle.
  assign w_mem_wr_int = i_mem_valid && (i_mem_regwrite == 2'b01) && (i_mem_rd != 5'd0);
  assign w_mem_wr_fpu = i_mem_valid && (i_mem_regwrite == 2'b10);
  assign w_mem_wr     = w_mem_wr_int || w_mem_wr_fpu;

  // Ready depends on occupancy only; a same-cycle dequeue does not free a slot.
  assign w_enq = i_fpu_valid && !w_full;
  assign w_deq = !w_mem_wr && !w_empty;

  // Kill first, then enqueue, so a result accepted on the kill edge survives.
  always_comb begin
    w_live_nxt = r_live;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_mem_wr_fpu && (r_rd[i] == i_mem_rd)) w_live_nxt[i] = 1'b0;
    end
    if (w_deq) w_live_nxt[r_head] = 1'b0;
    if (w_enq) w_live_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_pending[r_rd[i]] = 1'b1;
    end
  end

  // Payload storage needs no reset: r_live qualifies every entry.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_rd[r_tail]   <= i_fpu_rd;
      r_data[r_tail] <= i_fpu_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_live  <= w_live_nxt;
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_wb       <= '0;
      r_data_wb     <= '0;
      r_regwrite_wb <= 2'b00;
    end else if (w_mem_wr) begin
      r_rd_wb       <= i_mem_rd;
      r_data_wb     <= i_mem_data;
      r_regwrite_wb <= i_mem_regwrite;
    end else if (w_deq) begin
      // A killed entry still dequeues, but as a no-write.
      r_rd_wb       <= r_rd[r_head];
      r_data_wb     <= r_data[r_head];
      r_regwrite_wb <= r_live[r_head] ? 2'b10 : 2'b00;
    end else begin
      r_regwrite_wb <= 2'b00;
    end
  end

  assign o_fpu_ready              = !w_full;
  assign o_fpu_pending            = w_pending;
  assign o_rd_wb                  = r_rd_wb;
  assign o_write_data_register_wb = r_data_wb;
  assign o_regwrite_wb            = r_regwrite_wb;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//   Self-checking bench for writeback_arbiter. A queue-based reference model
//   predicts the write port, fpu_ready and fpu_pending every cycle; a directed
//   vector table, fill/drain and reset sequences and a random phase drive it.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_regwrite;
  logic [31:0] mem_data;
  logic        fpu_valid;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        fpu_ready;
  logic [4:0]  rd_wb;
  logic [31:0] data_wb;
  logic [1:0]  regwrite_wb;
  logic [31:0] fpu_pending;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_mem_valid              (mem_valid),
    .i_mem_rd                 (mem_rd),
    .i_mem_regwrite           (mem_regwrite),
    .i_mem_data               (mem_data),
    .i_fpu_valid              (fpu_valid),
    .i_fpu_rd                 (fpu_rd),
    .i_fpu_data               (fpu_data),
    .o_fpu_ready              (fpu_ready),
    .o_rd_wb                  (rd_wb),
    .o_write_data_register_wb (data_wb),
    .o_regwrite_wb            (regwrite_wb),
    .o_fpu_pending            (fpu_pending)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          alive;
  } ent_t;

  typedef struct {
    bit          mv;
    logic [4:0]  mrd;
    logic [1:0]  mrw;
    logic [31:0] mdat;
    bit          fv;
    logic [4:0]  frd;
    logic [31:0] fdat;
    logic [1:0]  erw;
    logic [4:0]  erd;
    logic [31:0] edat;
    bit          dc;
    logic [31:0] epend;
  } vec_t;

  ent_t        q[$];
  logic [31:0] fpu_log[$];
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_known;
  bit          last_acc;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[k]) if (q[k].alive) p[q[k].rd] = 1'b1;
    return p;
  endfunction

  // One clock of the reference model; inputs must already be driven.
  task automatic step();
    logic [1:0] e_rw;
    bit wr_int, wr_fpu, acc;
    ent_t h;
    chk("fpu_ready", 32'(fpu_ready), 32'(q.size() < DEPTH));
    chk("fpu_pending", fpu_pending, model_pending());
    wr_int = mem_valid && (mem_regwrite == 2'b01) && (mem_rd != 5'd0);
    wr_fpu = mem_valid && (mem_regwrite == 2'b10);
    acc    = fpu_valid && (q.size() < DEPTH);
    e_rw   = 2'b00;
    if (wr_int || wr_fpu) begin
      e_rw = mem_regwrite; m_rd = mem_rd; m_data = mem_data; m_known = 1'b1;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      if (h.alive) begin
        e_rw = 2'b10; m_rd = h.rd; m_data = h.data; m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
    if (wr_fpu) foreach (q[k]) if (q[k].rd == mem_rd) q[k].alive = 1'b0;
    if (acc) q.push_back('{rd: fpu_rd, data: fpu_data, alive: 1'b1});
    last_acc = acc;
    @(posedge clk); #1;
    chk("regwrite_wb", 32'(regwrite_wb), 32'(e_rw));
    if (m_known) begin
      chk("rd_wb", 32'(rd_wb), 32'(m_rd));
      chk("data_wb", data_wb, m_data);
    end
    if (regwrite_wb == 2'b10 && !wr_fpu) fpu_log.push_back(data_wb);
  endtask

  task automatic drive(input bit mv, input logic [4:0] mrd, input logic [1:0] mrw,
                       input logic [31:0] mdat, input bit fv, input logic [4:0] frd,
                       input logic [31:0] fdat);
    mem_valid = mv; mem_rd = mrd; mem_regwrite = mrw; mem_data = mdat;
    fpu_valid = fv; fpu_rd = frd; fpu_data = fdat;
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = '0; m_data = '0; m_known = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    model_reset();

    // Reset values must appear before any clock edge.
    #3;
    chk("rst_rd", 32'(rd_wb), 32'd0);
    chk("rst_data", data_wb, 32'd0);
    chk("rst_rw", 32'(regwrite_wb), 32'd0);
    chk("rst_ready", 32'(fpu_ready), 32'd1);
    chk("rst_pending", fpu_pending, 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    tbl[0] = '{1'b1, 5'd5, 2'b01, 32'h12345678, 1'b0, 5'd0, 32'h0,
               2'b01, 5'd5, 32'h12345678, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 5'd0, 2'b01, 32'hDEAD0000, 1'b1, 5'd9, 32'h11,
               2'b00, 5'd5, 32'h12345678, 1'b0, 32'h200};
    tbl[2] = '{1'b1, 5'd0, 2'b01, 32'hDEAD0001, 1'b0, 5'd0, 32'h0,
               2'b10, 5'd9, 32'h11, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 5'd4, 2'b11, 32'h77, 1'b0, 5'd0, 32'h0,
               2'b00, 5'd9, 32'h11, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 5'd2, 2'b01, 32'h22, 1'b1, 5'd7, 32'hAAAA0000,
               2'b01, 5'd2, 32'h22, 1'b0, 32'h80};
    tbl[5] = '{1'b1, 5'd7, 2'b10, 32'h55550000, 1'b0, 5'd0, 32'h0,
               2'b10, 5'd7, 32'h55550000, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 5'd0, 32'h0,
               2'b00, 5'd0, 32'h0, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 5'd3, 2'b10, 32'hF3F3, 1'b1, 5'd3, 32'h3333,
               2'b10, 5'd3, 32'hF3F3, 1'b0, 32'h8};
    tbl[8] = '{1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 5'd0, 32'h0,
               2'b10, 5'd3, 32'h3333, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 5'd0, 32'h0,
               2'b00, 5'd3, 32'h3333, 1'b0, 32'h0};
    foreach (tbl[i]) begin
      drive(tbl[i].mv, tbl[i].mrd, tbl[i].mrw, tbl[i].mdat,
            tbl[i].fv, tbl[i].frd, tbl[i].fdat);
      step();
      chk($sformatf("vec%0d_rw", i), 32'(regwrite_wb), 32'(tbl[i].erw));
      if (!tbl[i].dc) begin
        chk($sformatf("vec%0d_rd", i), 32'(rd_wb), 32'(tbl[i].erd));
        chk($sformatf("vec%0d_data", i), data_wb, tbl[i].edat);
      end
      chk($sformatf("vec%0d_pend", i), fpu_pending, tbl[i].epend);
      chk($sformatf("vec%0d_ready", i), 32'(fpu_ready), 32'd1);
    end

    // Fill with the pipeline busy, then drain in order.
    fpu_log.delete();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'(c + 1), 2'b01, 32'h1000 + c, n < 5, 5'(10 + n), 32'hF000_0000 + n);
      step();
      if (last_acc) n++;
    end
    chk("fill_ready_low", 32'(fpu_ready), 32'd0);
    chk("fill_f5_held", n, 4);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, '0, '0, '0, n < 5, 5'(10 + n), 32'hF000_0000 + n);
      step();
      if (last_acc) n++;
    end
    chk("drain_count", fpu_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < fpu_log.size()) chk($sformatf("drain_order%0d", k), fpu_log[k], 32'hF000_0000 + k);
    end
    chk("drain_pending", fpu_pending, 32'd0);
    chk("drain_ready", 32'(fpu_ready), 32'd1);

    // Asynchronous reset with three results queued.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd1, 2'b01, 32'hCAFE0000 + c, 1'b1, 5'(20 + c), 32'hB0000000 + c);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    chk("pre_rst_pending", fpu_pending, 32'h0070_0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", 32'(rd_wb), 32'd0);
    chk("arst_data", data_wb, 32'd0);
    chk("arst_rw", 32'(regwrite_wb), 32'd0);
    chk("arst_ready", 32'(fpu_ready), 32'd1);
    chk("arst_pending", fpu_pending, 32'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    fpu_log.delete();
    for (int c = 0; c < 6; c++) step();
    chk("post_rst_no_fpu_write", fpu_log.size(), 0);

    // Random traffic on a small register range to provoke kills.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom, ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    for (int c = 0; c < DEPTH + 2; c++) step();
    chk("final_pending", fpu_pending, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 DEPTH, 4, FPU result FIFO entries; power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_valid  in  1  MEM/WB pipeline slot holds an instruction this cycle.
REQ-005 mem_rd  in  5  destination register of the pipeline instruction.
REQ-006 mem_regwrite  in  2  01 = integer write, 10 = FPU write, 00/11 = no write.
REQ-007 mem_data  in  32  pipeline writeback data.
REQ-008 fpu_valid  in  1  multi-cycle FPU unit offers a result.
REQ-009 fpu_rd  in  5  FPU result destination register (always FPU bank).
REQ-010 fpu_data  in  32  FPU result data.
REQ-011 fpu_ready  out  1  FIFO can accept; equals !full, combinational from state only.
REQ-012 rd_wb  out  5  register-file write address, registered.
REQ-013 write_data_register_wb  out  32  register-file write data, registered.
REQ-014 regwrite_wb  out  2  register-file write enable/bank (00/01/10), registered.
REQ-015 fpu_pending  out  32  bit i set iff a valid FIFO entry targets FPU register i; combinational from FIFO state; used by ID for stalls.

Function
REQ-016 Single register-file write port; at most one write issued per cycle.
REQ-017 FPU handshake: the result is accepted on an edge where fpu_valid && fpu_ready; it is then enqueued at the FIFO tail.
REQ-018 When full, fpu_ready = 0, even if a dequeue occurs in the same cycle.
REQ-019 Pipeline priority: if mem_valid and mem_regwrite is 01 or 10, the next edge loads {mem_rd, mem_data, mem_regwrite} onto the write port, and the FIFO does not dequeue.
REQ-020 An integer write to mem_rd = 0 is suppressed: regwrite_wb = 00 next cycle and the slot counts as idle, so the FIFO may drain.
REQ-021 mem_regwrite = 11 is treated as 00.
REQ-022 Idle slot: if the FIFO is non-empty, the next edge dequeues the head and drives {head.rd, head.data, 10}.
REQ-023 Idle slot with an empty FIFO: the next edge drives regwrite_wb = 00 and holds rd_wb and the data at their previous values.
REQ-024 Latency: pipeline write reaches the port 1 edge after presentation. FPU result accepted at edge E reaches the port no earlier than edge E+1. No bypass around the FIFO.
REQ-025 Order: FIFO entries are written to the port in acceptance order.
REQ-026 WAW kill: a pipeline FPU write (10) to register r invalidates every valid FIFO entry with rd = r on the same edge.
  - Killed entries still occupy their slot until dequeued.
  - A killed entry's dequeue produces regwrite_wb = 00.
  - A killed entry's bit is removed from fpu_pending immediately.
REQ-027 A result enqueued on the same edge as a WAW kill to the same register is not killed, because it is younger.
REQ-028 Simultaneous enqueue and dequeue when neither full nor empty: the count is unchanged.
REQ-029 Simultaneous enqueue and dequeue when empty: a dequeue requires a non-empty FIFO, so only the enqueue occurs.
REQ-030 Pointers are log2(DEPTH) bits wide with a separate count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Reset
REQ-031 While rst = 1, with no clock edge required:
  - rd_wb = 0, write_data_register_wb = 0, regwrite_wb = 00;
  - FIFO empty, all entries invalid, fpu_pending = 0, fpu_ready = 1.
REQ-032 Reset mid-operation discards every queued FPU result. No write is issued from them after reset deasserts.
REQ-033 The first write after rst falls is the first edge-sampled input.

Verification
REQ-034 Pipeline integer write: mem_valid = 1, rd 5, 01, data 0x12345678 -> next cycle rd_wb = 5, data 0x12345678, regwrite_wb = 01.
REQ-035 Pipeline integer write to x0: mem_valid = 1, rd 0, 01 -> regwrite_wb = 00; a queued FPU entry drains in that slot instead.
REQ-036 FIFO fill and drain:
  - stimulus: DEPTH = 4; five back-to-back FPU results f1..f5 while the pipeline writes every cycle;
  - required: fpu_ready drops after the 4th acceptance and f5 is held;
  - after the pipeline goes idle: f1..f4 then f5 are written in order with regwrite_wb = 10, and fpu_pending returns to 0.
REQ-037 WAW kill: FIFO holds f7 = 0xAAAA0000 -> pipeline FPU write rd 7, data 0x55550000 -> port writes 0x55550000; the later dequeue of the f7 entry gives regwrite_wb = 00; fpu_pending[7] clears on the kill edge.
REQ-038 Kill versus enqueue on the same edge: pipeline FPU write rd 3 on the same edge an FPU result for f3 is accepted -> the new entry survives and is written later with regwrite_wb = 10.
REQ-039 Async reset: assert rst mid-cycle with 3 entries queued -> outputs zero immediately, fpu_ready = 1, and no FPU write appears after release.
